// File: rtl/exc_commit_ctrl.sv
// Commit-point trap/return sequencer: picks the winning WB exception, interrupt or ERTN,
// pulses the CSR file once, then holds flush and an IF redirect until IF takes it.
module exc_commit_ctrl #(
    parameter int unsigned FLUSH_MIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [5:0]  wb_exc,
    input  logic        wb_ertn,
    input  logic        int_signal,
    input  logic [31:0] csr_target,
    output logic        exc_signal,
    output logic        ertn_signal,
    output logic [5:0]  exc_ecode,
    output logic [8:0]  exc_esubcode,
    output logic [31:0] exc_pc,
    output logic [31:0] exc_vaddr,
    output logic        flush,
    output logic        wb_block,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        RET      = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [3:0]  hold_cnt;
    logic        trap_req;
    logic        ret_req;
    logic        flush_done;
    logic [5:0]  cause_ecode;
    logic [8:0]  cause_sub;
    logic [31:0] cause_vaddr;

    assign trap_req   = wb_valid && (int_signal || (|wb_exc));
    assign ret_req    = wb_valid && wb_ertn && !trap_req;
    assign flush_done = 32'(hold_cnt) >= FLUSH_MIN;

    // Fixed priority: interrupt first, then exceptions in pipeline-stage order.
    always_comb begin
        cause_ecode = 6'h00;
        cause_sub   = 9'd0;
        cause_vaddr = 32'd0;
        if (int_signal) begin
            cause_ecode = 6'h00;
        end else if (wb_exc[0]) begin
            cause_ecode = 6'h08;
            cause_vaddr = wb_pc;
        end else if (wb_exc[1]) begin
            cause_ecode = 6'h0D;
        end else if (wb_exc[2]) begin
            cause_ecode = 6'h0B;
        end else if (wb_exc[3]) begin
            cause_ecode = 6'h0C;
        end else if (wb_exc[4]) begin
            cause_ecode = 6'h09;
            cause_vaddr = wb_vaddr;
        end else if (wb_exc[5]) begin
            cause_ecode = 6'h08;
            cause_sub   = 9'd1;
            cause_vaddr = wb_vaddr;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (trap_req) begin
                    state_next = TRAP;
                end else if (ret_req) begin
                    state_next = RET;
                end
            end
            TRAP, RET: state_next = REDIRECT;
            REDIRECT: begin
                if (redirect_ready && flush_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            hold_cnt     <= 4'd0;
            exc_ecode    <= 6'd0;
            exc_esubcode <= 9'd0;
            exc_pc       <= 32'd0;
            exc_vaddr    <= 32'd0;
            redirect_pc  <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && trap_req) begin
                exc_ecode    <= cause_ecode;
                exc_esubcode <= cause_sub;
                exc_pc       <= wb_pc;
                exc_vaddr    <= cause_vaddr;
            end else if (state == IDLE && ret_req) begin
                exc_ecode    <= 6'd0;
                exc_esubcode <= 9'd0;
                exc_pc       <= wb_pc;
                exc_vaddr    <= 32'd0;
            end
            // The CSR file presents eentry/era during the pulse cycle; capture it there.
            if (state == TRAP || state == RET) begin
                redirect_pc <= csr_target;
                hold_cnt    <= 4'd1;
            end else if (state == REDIRECT && hold_cnt != 4'd15) begin
                hold_cnt <= hold_cnt + 4'd1;
            end
        end
    end

    assign exc_signal     = (state == TRAP);
    assign ertn_signal    = (state == RET);
    assign flush          = (state != IDLE);
    assign wb_block       = (state != IDLE);
    assign redirect_valid = (state == REDIRECT);

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: instance a uses FLUSH_MIN=2, instance b uses FLUSH_MIN=4;
// both see the same WB/CSR/IF stimulus.
module tb_exc_commit_ctrl;

    typedef struct packed {
        logic        is_ret;
        logic [5:0]  ecode;
        logic [8:0]  sub;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [5:0]  wb_exc;
    logic        wb_ertn;
    logic        int_signal;
    logic [31:0] csr_target;
    logic        redirect_ready;

    logic        a_exc_signal, a_ertn_signal, a_flush, a_wb_block, a_redirect_valid;
    logic [5:0]  a_ecode;
    logic [8:0]  a_sub;
    logic [31:0] a_pc, a_vaddr, a_redirect_pc;
    logic        b_exc_signal, b_ertn_signal, b_flush, b_wb_block, b_redirect_valid;
    logic [5:0]  b_ecode;
    logic [8:0]  b_sub;
    logic [31:0] b_pc, b_vaddr, b_redirect_pc;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   a_pulses = 0;
    int   b_pulses = 0;

    exc_commit_ctrl #(.FLUSH_MIN(2)) dut_a (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_exc(wb_exc), .wb_ertn(wb_ertn), .int_signal(int_signal), .csr_target(csr_target),
        .exc_signal(a_exc_signal), .ertn_signal(a_ertn_signal), .exc_ecode(a_ecode),
        .exc_esubcode(a_sub), .exc_pc(a_pc), .exc_vaddr(a_vaddr), .flush(a_flush),
        .wb_block(a_wb_block), .redirect_valid(a_redirect_valid), .redirect_pc(a_redirect_pc),
        .redirect_ready(redirect_ready)
    );

    exc_commit_ctrl #(.FLUSH_MIN(4)) dut_b (
        .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .wb_exc(wb_exc), .wb_ertn(wb_ertn), .int_signal(int_signal), .csr_target(csr_target),
        .exc_signal(b_exc_signal), .ertn_signal(b_ertn_signal), .exc_ecode(b_ecode),
        .exc_esubcode(b_sub), .exc_pc(b_pc), .exc_vaddr(b_vaddr), .flush(b_flush),
        .wb_block(b_wb_block), .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .redirect_ready(redirect_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (a_exc_signal || a_ertn_signal) a_pulses++;
        if (b_exc_signal || b_ertn_signal) b_pulses++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [5:0] exc, input logic ertn, input logic intr,
                                   input logic [31:0] pc, input logic [31:0] va);
        exp_t m;
        m = '0;
        m.pc = pc;
        if (intr)        m.ecode = 6'h00;
        else if (exc[0]) begin m.ecode = 6'h08; m.vaddr = pc; end
        else if (exc[1]) m.ecode = 6'h0D;
        else if (exc[2]) m.ecode = 6'h0B;
        else if (exc[3]) m.ecode = 6'h0C;
        else if (exc[4]) begin m.ecode = 6'h09; m.vaddr = va; end
        else if (exc[5]) begin m.ecode = 6'h08; m.sub = 9'd1; m.vaddr = va; end
        else if (ertn)   m.is_ret = 1'b1;
        return m;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_a"}, {27'd0, a_exc_signal, a_ertn_signal, a_flush, a_wb_block, a_redirect_valid}, 32'd0);
        check({tag, "_b"}, {27'd0, b_exc_signal, b_ertn_signal, b_flush, b_wb_block, b_redirect_valid}, 32'd0);
    endtask

    task automatic clear_wb();
        wb_valid = 1'b0; wb_exc = 6'd0; wb_ertn = 1'b0; int_signal = 1'b0;
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic run_txn(input logic valid, input logic [5:0] exc, input logic ertn,
                           input logic intr, input logic [31:0] pc, input logic [31:0] va,
                           input logic [31:0] tgt);
        exp_t e;
        logic req;
        int   n;
        @(negedge clk);
        wb_valid = valid; wb_exc = exc; wb_ertn = ertn; int_signal = intr;
        wb_pc = pc; wb_vaddr = va; csr_target = tgt;
        req = valid && (intr || (|exc) || ertn);
        if (req) exp_q.push_back(model(exc, ertn, intr, pc, va));
        @(negedge clk);
        clear_wb();
        if (!req) begin
            check("no_req_pulse", {30'd0, a_exc_signal, a_ertn_signal}, 32'd0);
            check("no_req_flush", {31'd0, a_flush}, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("exc_signal", {31'd0, a_exc_signal}, {31'd0, !e.is_ret});
        check("ertn_signal", {31'd0, a_ertn_signal}, {31'd0, e.is_ret});
        check("ecode", {26'd0, a_ecode}, {26'd0, e.ecode});
        check("esubcode", {23'd0, a_sub}, {23'd0, e.sub});
        check("exc_pc", a_pc, e.pc);
        check("exc_vaddr", a_vaddr, e.vaddr);
        check("pulse_flush", {30'd0, a_flush, a_wb_block}, 32'd3);
        check("pulse_no_redirect", {31'd0, a_redirect_valid}, 32'd0);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!a_redirect_valid) break;
            n++;
            check("redirect_pc", a_redirect_pc, tgt);
            check("redirect_hold", {29'd0, a_flush, a_wb_block, a_exc_signal | a_ertn_signal}, 32'd6);
        end
        // ready held high: exit on the edge where hold_cnt first reaches FLUSH_MIN=2
        check("redirect_cycles", n, 32'd2);
        check("after_exit_a", {29'd0, a_flush, a_wb_block, a_redirect_valid}, 32'd0);
        for (int k = 0; k < 40; k++) begin
            if (!b_flush) break;
            @(negedge clk);
        end
        check_idle("both_idle");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0;
        logic [31:0] held_pc;
        reset = 1'b1; redirect_ready = 1'b1; clear_wb();
        wb_pc = 32'd0; wb_vaddr = 32'd0; csr_target = 32'd0;
        repeat (3) @(negedge clk);
        check_idle("reset_state");
        check("reset_cause", {26'd0, a_ecode} | a_pc | a_vaddr | a_redirect_pc | {23'd0, a_sub}, 32'd0);
        reset = 1'b0;

        run_txn(1, 6'b000100, 0, 0, 32'h1C00_0010, 32'h0, 32'h1C00_8000);
        run_txn(1, 6'b110010, 0, 1, 32'h1C00_0020, 32'h0000_1003, 32'h1C00_8000);
        run_txn(1, 6'b110010, 0, 0, 32'h1C00_0024, 32'h0000_1003, 32'h1C00_8000);
        run_txn(1, 6'b100000, 0, 0, 32'h1C00_0030, 32'hDEAD_0001, 32'h1C00_8000);
        run_txn(1, 6'b000001, 0, 0, 32'h1C00_0003, 32'h0000_0000, 32'h1C00_8000);
        run_txn(1, 6'b010000, 0, 0, 32'h1C00_0040, 32'h0000_0006, 32'h1C00_8004);
        run_txn(1, 6'b001000, 0, 0, 32'h1C00_0044, 32'h0000_0000, 32'h1C00_8008);
        run_txn(1, 6'b000000, 1, 0, 32'h1C00_0050, 32'h0000_0000, 32'h1C00_0200);
        run_txn(1, 6'b000100, 1, 0, 32'h1C00_0054, 32'h0000_0000, 32'h1C00_8000);
        run_txn(0, 6'b000100, 1, 1, 32'h1C00_0058, 32'h0000_0000, 32'h1C00_8000);
        for (int i = 0; i < 12; i++) begin
            run_txn(1, 6'($urandom_range(0, 63)) & 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 3) == 0), $urandom, $urandom, $urandom);
        end

        // long hold on the FLUSH_MIN=4 instance, with a new exception arriving mid-hold
        p0 = b_pulses;
        @(negedge clk);
        redirect_ready = 1'b0;
        wb_valid = 1'b1; wb_exc = 6'b000100; wb_pc = 32'h1C00_0100; csr_target = 32'h1C00_9000;
        @(negedge clk);
        clear_wb();
        check("b_trap_pulse", {31'd0, b_exc_signal}, 32'd1);
        check("b_trap_ecode", {26'd0, b_ecode}, 32'h0B);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) held_pc = b_redirect_pc;
            if (i == 2) begin wb_valid = 1'b1; wb_exc = 6'b000010; csr_target = 32'h1C00_AAAA; end
            if (i == 3) clear_wb();
            check("b_hold_valid", {30'd0, b_redirect_valid, b_flush}, 32'd3);
            check("b_hold_pc", b_redirect_pc, 32'h1C00_9000);
        end
        check("b_hold_pc_const", b_redirect_pc, held_pc);
        redirect_ready = 1'b1;
        @(negedge clk);
        check("b_exit", {29'd0, b_redirect_valid, b_flush, b_wb_block}, 32'd0);
        check("a_exit", {29'd0, a_redirect_valid, a_flush, a_wb_block}, 32'd0);
        repeat (2) @(negedge clk);
        check("b_single_pulse", b_pulses - p0, 32'd1);

        // asynchronous reset in the middle of a redirect
        @(negedge clk);
        wb_valid = 1'b1; wb_exc = 6'b001000; wb_pc = 32'h1C00_0200; csr_target = 32'h1C00_7000;
        redirect_ready = 1'b0;
        @(negedge clk);
        clear_wb();
        @(negedge clk);
        check("pre_reset_redirect", {31'd0, a_redirect_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_idle("async_reset");
        check("async_reset_pc", a_redirect_pc | b_redirect_pc | a_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        redirect_ready = 1'b1;
        p0 = a_pulses;
        repeat (4) begin
            @(negedge clk);
            check_idle("post_reset");
        end
        check("post_reset_pulses", a_pulses - p0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
